// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
//
// Receives 8E1 serial frames: start bit (0), 8 data bits LSB first, an even
// parity bit and one stop bit (1). The line is resynchronised through two
// flops before any decision is made. Each bit is sampled at its centre. The
// start bit is sampled HALF clocks after it is detected, and every later bit
// is sampled BIT_DELAY clocks after the previous sample.
//
// Parameters
//   CLK_FREQ   clock frequency in Hz
//   BAUD_RATE  line bit rate; BIT_DELAY = CLK_FREQ/BAUD_RATE must be >= 4
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   rx          serial line, idle high
//   data_out    last accepted byte
//   data_valid  data_out holds a byte that has not been consumed yet
//   data_ready  consumer takes data_out when data_valid && data_ready
//   parity_err  one-cycle pulse: received parity did not match
//   frame_err   one-cycle pulse: stop bit was sampled low
//   overrun     one-cycle pulse: good byte dropped because the buffer was full
//   busy        high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_receiver #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       data_ready,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int BIT_DELAY = CLK_FREQ / BAUD_RATE;
    localparam int HALF      = BIT_DELAY / 2;
    localparam int CNT_W     = $clog2(BIT_DELAY);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_DELAY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       bit_cnt_reg;
    logic [7:0]       shift_reg;
    logic             par_reg;
    logic             par_bad_reg;
    logic             rx_meta_reg;
    logic             rx_sync_reg;

    assign busy = (state_reg != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            par_reg     <= 1'b0;
            par_bad_reg <= 1'b0;
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            data_out    <= 8'h00;
            data_valid  <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;

            // Flags are single-cycle pulses; they are raised only on the
            // cycle that follows the stop sample.
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;

            // Plain consumption. A load in the stop-sample cycle below
            // overrides this, so a byte taken in that cycle is replaced.
            if (data_valid && data_ready)
                data_valid <= 1'b0;

            unique case (state_reg)
                S_IDLE: begin
                    if (!rx_sync_reg) begin
                        state_reg <= S_START;
                        cnt_reg   <= '0;
                    end
                end

                S_START: begin
                    if (cnt_reg == HALF_LAST) begin
                        cnt_reg <= '0;
                        if (rx_sync_reg) begin
                            // Line went high again before mid-bit: a glitch.
                            state_reg <= S_IDLE;
                        end else begin
                            state_reg   <= S_DATA;
                            bit_cnt_reg <= '0;
                            par_reg     <= 1'b0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                S_DATA: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_reg     <= '0;
                        // Shift in at the MSB so the first (LSB) bit ends in bit 0.
                        shift_reg   <= {rx_sync_reg, shift_reg[7:1]};
                        par_reg     <= par_reg ^ rx_sync_reg;
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        if (bit_cnt_reg == 3'd7)
                            state_reg <= S_PARITY;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                S_PARITY: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_reg     <= '0;
                        par_bad_reg <= (rx_sync_reg != par_reg);
                        state_reg   <= S_STOP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                S_STOP: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_reg <= '0;
                        if (!rx_sync_reg) begin
                            // A framing error masks any parity error.
                            frame_err <= 1'b1;
                            state_reg <= S_WAIT_IDLE;
                        end else begin
                            // Go straight back to IDLE so a start bit that
                            // follows the stop bit with no gap is still caught.
                            state_reg <= S_IDLE;
                            if (par_bad_reg) begin
                                parity_err <= 1'b1;
                            end else if (!data_valid || data_ready) begin
                                data_out   <= shift_reg;
                                data_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                S_WAIT_IDLE: begin
                    // A line held low (break) must not be taken as a new start bit.
                    if (rx_sync_reg)
                        state_reg <= S_IDLE;
                end

                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver
//
// Directed bench for uart_receiver with BIT_DELAY=16 and HALF=8. Expected
// receiver events (byte loads and error pulses) are queued as each frame is
// sent. A monitor pops them as the DUT raises them. Direct state checks are
// placed between the steps.
// ---------------------------------------------------------------------------
module tb_uart_receiver;

    localparam int BD = 16;

    localparam logic [7:0] EV_DATA = 8'd0;
    localparam logic [7:0] EV_PAR  = 8'd1;
    localparam logic [7:0] EV_FRM  = 8'd2;
    localparam logic [7:0] EV_OVR  = 8'd3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       data_ready;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_q[$];
    int          cyc = 0;
    int          frame_start = 0;
    int          last_data_cyc = -1;
    logic        prev_valid = 1'b0;
    logic [7:0]  prev_out = 8'h00;

    uart_receiver #(
        .CLK_FREQ (16),
        .BAUD_RATE(1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data_ready(data_ready),
        .data_out  (data_out),
        .data_valid(data_valid),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_event(input logic [7:0] kind, input logic [7:0] value);
        exp_q.push_back({kind, value});
    endtask

    task automatic note_event(input logic [7:0] kind, input logic [7:0] value);
        logic [15:0] exp;
        if (exp_q.size() == 0) begin
            // Any event with nothing queued is a failure; 16'hFFFF never matches.
            check("unexpected_event", {16'h0, kind, value}, 32'hFFFF);
        end else begin
            exp = exp_q.pop_front();
            check("event", {16'h0, kind, value}, {16'h0, exp});
        end
        $display("event kind=%0d value=0x%02h cycle=%0d", kind, value, cyc);
    endtask

    // Output monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (parity_err) note_event(EV_PAR, 8'h00);
            if (frame_err)  note_event(EV_FRM, 8'h00);
            if (overrun)    note_event(EV_OVR, 8'h00);
            if (data_valid && (!prev_valid || data_out != prev_out)) begin
                last_data_cyc = cyc;
                note_event(EV_DATA, data_out);
            end
        end
        prev_valid = data_valid;
        prev_out   = data_out;
    end

    // Starts and ends on a falling edge. The whole frame lasts 11 bit times.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        $display("send data=0x%02h parity=%0d stop=%0d", d, p, s);
        frame_start = cyc;
        rx = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BD) @(negedge clk);
        end
        rx = p;
        repeat (BD) @(negedge clk);
        rx = s;
        repeat (BD) @(negedge clk);
    endtask

    task automatic consume();
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        rx         = 1'b1;
        data_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_data_out",   data_out,   8'h00);
        check("reset_data_valid", data_valid, 1'b0);
        check("reset_flags",      {parity_err, frame_err, overrun}, 3'b000);
        check("reset_busy",       busy,       1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Good frame 0xA5 with the consumer stalled.
        expect_event(EV_DATA, 8'hA5);
        send_frame(8'hA5, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        // rx falls, two synchroniser flops, IDLE sees it, then HALF + 10*BD.
        check("a5_latency",    last_data_cyc, frame_start + 3 + 8 + 10 * BD);
        check("a5_data_out",   data_out,   8'hA5);
        check("a5_data_valid", data_valid, 1'b1);
        consume();
        check("a5_consumed_valid", data_valid, 1'b0);
        check("a5_consumed_out",   data_out,   8'hA5);

        // Parity error: 0x01 needs parity 1.
        expect_event(EV_PAR, 8'h00);
        send_frame(8'h01, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("par_data_valid", data_valid, 1'b0);
        check("par_data_out",   data_out,   8'hA5);

        // Framing error with the line held low as a break.
        expect_event(EV_FRM, 8'h00);
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        check("break_busy", busy, 1'b1);
        rx = 1'b1;
        repeat (6) @(negedge clk);
        check("break_idle",       busy,       1'b0);
        check("break_data_valid", data_valid, 1'b0);
        check("break_data_out",   data_out,   8'hA5);

        // Short glitch in IDLE: no event is expected.
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check("glitch_busy_during", busy, 1'b1);
        repeat (20) @(negedge clk);
        check("glitch_busy",  busy,       1'b0);
        check("glitch_valid", data_valid, 1'b0);
        check("glitch_out",   data_out,   8'hA5);

        // Back-to-back frames with the consumer stalled: the second overruns.
        expect_event(EV_DATA, 8'h11);
        expect_event(EV_OVR,  8'h00);
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("ovr_data_out",   data_out,   8'h11);
        check("ovr_data_valid", data_valid, 1'b1);
        consume();
        check("ovr_consumed", data_valid, 1'b0);

        // Repeat, with data_ready high only in the second stop-sample cycle.
        expect_event(EV_DATA, 8'h11);
        expect_event(EV_DATA, 8'h22);
        send_frame(8'h11, 1'b0, 1'b1);
        fork
            send_frame(8'h22, 1'b0, 1'b1);
            begin
                repeat (3 + 8 + 10 * BD - 1) @(negedge clk);
                data_ready = 1'b1;
                @(negedge clk);
                data_ready = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        check("ready_data_out",   data_out,   8'h22);
        check("ready_data_valid", data_valid, 1'b1);
        consume();

        // Reset in the middle of frame 0x55, then frame 0x66.
        rx = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = 1'((8'h55 >> i) & 8'h01);
            repeat (BD) @(negedge clk);
        end
        check("mid_frame_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_reset_busy",  busy,       1'b0);
        check("async_reset_out",   data_out,   8'h00);
        check("async_reset_valid", data_valid, 1'b0);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_reset_idle", busy, 1'b0);
        expect_event(EV_DATA, 8'h66);
        send_frame(8'h66, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("resume_data_out",   data_out,   8'h66);
        check("resume_data_valid", data_valid, 1'b1);

        repeat (10) @(negedge clk);
        check("events_outstanding", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, line bit rate; BIT_DELAY = CLK_FREQ/BAUD_RATE clocks per bit, HALF = BIT_DELAY/2 (integer divide); BIT_DELAY >= 4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rx  input  1  asynchronous serial line, idle high; frame format 8E1: start (0), 8 data LSB first, even parity, 1 stop (1).
REQ-006 data_out  output  8  last accepted byte.
REQ-007 data_valid  output  1  data_out holds an unconsumed byte.
REQ-008 data_ready  input  1  consumer accepts data_out when data_valid && data_ready at a rising edge.
REQ-009 parity_err  output  1  one-cycle pulse: parity mismatch on the received frame.
REQ-010 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 overrun  output  1  one-cycle pulse: good frame dropped because the buffer was full.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer (rx_sync); all decisions use rx_sync only.
REQ-014 States SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_IDLE; one bit-timing counter; one 3-bit data-bit counter.
REQ-015 IDLE: rx_sync==0 -> START with counter cleared; otherwise stay.
REQ-016 START: after HALF cycles, sample rx_sync; 1 -> IDLE (glitch, no flags); 0 -> DATA, counter cleared, bit counter 0, running parity 0.
REQ-017 DATA: every BIT_DELAY cycles sample rx_sync into shift register MSB, shifting right (first bit ends in bit 0), XOR into running parity; after the 8th sample -> PARITY.
REQ-018 PARITY: after BIT_DELAY cycles sample rx_sync as parity bit; mismatch = sample != running parity (even parity over 8 data bits); -> STOP.
REQ-019 STOP: after BIT_DELAY cycles sample stop bit (the stop-sample cycle); stop==1 -> IDLE, stop==0 -> WAIT_IDLE.
REQ-020 WAIT_IDLE: stay until rx_sync==1, then -> IDLE (line break must not restart reception).
REQ-021 Stop-sample outcome, next cycle: stop==0 -> frame_err pulse, byte discarded; else parity mismatch -> parity_err pulse, byte discarded; else byte is good.
REQ-022 frame_err and parity_err SHALL never pulse together; frame_err has priority.
REQ-023 Good byte with data_valid==0, or with data_valid && data_ready in the stop-sample cycle: data_out loaded, data_valid=1 next cycle, no overrun.
REQ-024 Good byte with data_valid==1 && data_ready==0: byte dropped, data_out unchanged, overrun pulses one cycle.
REQ-025 Consumption without new byte: data_valid && data_ready -> data_valid=0 next cycle; data_out holds value.
REQ-026 data_out SHALL change only on the load cycle of REQ-023.
REQ-027 Latency: stop sample at HALF + 10*BIT_DELAY clocks after IDLE first sees rx_sync==0; data_valid/error pulse in the following cycle.
REQ-028 New start bit detected in IDLE immediately after STOP; back-to-back frames with no idle gap SHALL be received.

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE, counters 0, synchronizer flops 1, data_out 0x00, data_valid 0, parity_err 0, frame_err 0, overrun 0, busy 0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame with no flag; after release, reception resumes on the next falling edge of rx_sync.

Verification (CLK_FREQ=16, BAUD_RATE=1: BIT_DELAY=16, HALF=8)
REQ-031 Frame 0xA5 with parity 0, stop 1, data_ready=0 -> data_out=0xA5, data_valid=1 at stop-sample+1, no flags; then data_ready=1 one cycle -> data_valid=0.
REQ-032 Frame 0x01 with parity 0 (wrong) -> parity_err one-cycle pulse, data_valid stays 0, data_out unchanged.
REQ-033 Frame 0x3C with stop bit 0, rx held low 40 cycles -> frame_err one pulse, busy stays 1 until rx high, no second frame detected.
REQ-034 rx low pulse of 4 cycles in IDLE -> returns to IDLE, no outputs change.
REQ-035 Two back-to-back good frames 0x11, 0x22, data_ready=0 -> data_out=0x11, overrun pulse on second; repeat with data_ready=1 in second stop-sample cycle -> data_out=0x22, no overrun, data_valid stays 1.
REQ-036 rst_n low during DATA of frame 0x55, release, send 0x66 -> only 0x66 delivered, no flags.
